// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the countdown timer.
// BCD helpers operate on a 32-bit word (up to 8 digits) and take the live digit count.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} timer_state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam int unsigned BCD_MAX_N = 8;

  typedef logic [4*BCD_MAX_N-1:0] bcd_word_t;

  // Clamp every nibble above 9 down to 9; digits beyond n are zeroed.
  function automatic bcd_word_t bcd_clamp(bcd_word_t v, int unsigned n);
    bcd_word_t r;
    r = '0;
    for (int unsigned i = 0; i < BCD_MAX_N; i++) begin
      if (i < n) r[4*i+:4] = (v[4*i+:4] > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : v[4*i+:4];
    end
    return r;
  endfunction

  // Subtract one with digit-wise borrow; zero stays zero.
  function automatic bcd_word_t bcd_dec(bcd_word_t v, int unsigned n);
    bcd_word_t r;
    logic      borrow;
    r      = v;
    borrow = (v != '0);
    for (int unsigned i = 0; i < BCD_MAX_N; i++) begin
      if (i < n && borrow) begin
        if (v[4*i+:4] == 4'd0) begin
          r[4*i+:4] = BCD_MAX_DIGIT;
        end else begin
          r[4*i+:4] = v[4*i+:4] - 4'd1;
          borrow    = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Digit-wise add; a carry out of the top digit saturates to all nines.
  function automatic bcd_word_t bcd_add_sat(bcd_word_t a, bcd_word_t b, int unsigned n);
    bcd_word_t  r;
    bcd_word_t  nines;
    logic       carry;
    logic [4:0] s;
    r     = '0;
    nines = '0;
    carry = 1'b0;
    for (int unsigned i = 0; i < BCD_MAX_N; i++) begin
      if (i < n) begin
        s = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'd0, carry};
        if (s > 5'd9) begin
          s     = s - 5'd10;
          carry = 1'b1;
        end else begin
          carry = 1'b0;
        end
        r[4*i+:4]     = s[3:0];
        nines[4*i+:4] = BCD_MAX_DIGIT;
      end
    end
    return carry ? nines : r;
  endfunction

  // Binary to n-digit BCD, saturating at all nines; used for elaboration constants.
  function automatic bcd_word_t bcd_from_uint_sat(int unsigned v, int unsigned n);
    bcd_word_t   r;
    bcd_word_t   nines;
    int unsigned rem;
    r     = '0;
    nines = '0;
    rem   = v;
    for (int unsigned i = 0; i < BCD_MAX_N; i++) begin
      if (i < n) begin
        r[4*i+:4]     = 4'(rem % 10);
        nines[4*i+:4] = BCD_MAX_DIGIT;
        rem           = rem / 10;
      end
    end
    return (rem != 0) ? nines : r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-TICK_DIV counter that only advances while enabled.
// A disabled prescaler holds its partial count so a resume finishes the current period.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick on the last count of a period; the counter wraps on that same cycle.
  always_comb begin
    tick  = en && (cnt_q == CntMax);
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + CntW'(1);
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD count-down game timer with start/pause control, expiry pulse and low-time flag.
// Optional bonus-time add port enabled by defining TIMER_ADD_TIME_EN.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 2,
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned LOW_THRESH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_digits,
  input  logic                  start,
  input  logic                  pause,
`ifdef TIMER_ADD_TIME_EN
  input  logic                  add_valid,
  input  logic [4*N_DIGITS-1:0] add_digits,
`endif
  output logic [4*N_DIGITS-1:0] digits,
  output logic                  running,
  output logic                  expired,
  output logic                  expired_pulse,
  output logic                  low_time
);

  localparam int unsigned W = 4 * N_DIGITS;
  // Threshold pre-encoded as BCD so the comparison is a plain unsigned compare.
  localparam bcd_word_t ThreshBcd = bcd_from_uint_sat(LOW_THRESH, N_DIGITS);

  timer_state_t state_q, state_d;
  logic [W-1:0] digits_q, digits_d;
  logic         pulse_q, pulse_d;
  logic         tick, pre_en, pre_clr;
  bcd_word_t    base_w, dec_w, load_w;

  // Prescaler halts on pause or load cycles so no tick is taken when control wins.
  assign pre_en  = (state_q == RUNNING) && !pause && !load;
  assign pre_clr = load || pulse_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  // State and digit registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      digits_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      pulse_q  <= pulse_d;
    end
  end

  // Next state and next digit value: load > pause > start > tick.
  always_comb begin
    load_w = bcd_clamp(bcd_word_t'(load_digits), N_DIGITS);
    base_w = bcd_word_t'(digits_q);
`ifdef TIMER_ADD_TIME_EN
    if (add_valid && (state_q == RUNNING || state_q == PAUSED)) begin
      base_w = bcd_add_sat(base_w, bcd_clamp(bcd_word_t'(add_digits), N_DIGITS), N_DIGITS);
    end
`endif
    dec_w    = bcd_dec(base_w, N_DIGITS);
    state_d  = state_q;
    digits_d = digits_q;
    pulse_d  = 1'b0;
    if (load) begin
      digits_d = W'(load_w);
      state_d  = IDLE;
    end else begin
      digits_d = W'(base_w);
      unique case (state_q)
        IDLE, PAUSED: begin
          if (start && !pause) begin
            if (base_w == '0) begin
              state_d = EXPIRED;
              pulse_d = 1'b1;
            end else begin
              state_d = RUNNING;
            end
          end
        end
        RUNNING: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            digits_d = W'(dec_w);
            if (dec_w == '0) begin
              state_d = EXPIRED;
              pulse_d = 1'b1;
            end
          end
        end
        EXPIRED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state and digits.
  always_comb begin
    digits        = digits_q;
    running       = (state_q == RUNNING);
    expired       = (state_q == EXPIRED);
    expired_pulse = pulse_q;
    low_time      = (state_q == RUNNING || state_q == PAUSED) && (digits_q <= W'(ThreshBcd));
  end

endmodule
